// File: rtl/wb_mpsram_pkg.sv
// wb_mpsram_pkg: shared definitions for the multi-port Wishbone SRAM controller.
//   state_t   - controller FSM states
//   CNT_W     - width of the wait-state down-counter
//   slice_lo  - low bit of port p's slice in a packed per-port bus
package wb_mpsram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot request arbiter, fixed priority or round-robin.
//   clk     - clock
//   rst     - synchronous active-high reset
//   req     - per-port requests
//   update  - grant is being taken; record it as the last winner
//   grant   - combinational one-hot grant (all zero when no request)
// In round-robin mode the search begins just above the last winner and
// wraps; last resets to NPORTS-1 so port 0 is favoured first.
module wb_rr_arbiter
    import wb_mpsram_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int RR     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic              update,
    output logic [NPORTS-1:0] grant
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] grant_idx;
    logic          found;

    // Two passes: ports above last first, then the wrapped ports at or
    // below last. In fixed mode the first pass already covers every port.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req[i] && (RR == 0 || i > int'(last_q))) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(NPORTS - 1);
        end else if (update && found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/wb_mpsram.sv
// wb_mpsram: multi-port Wishbone slave to asynchronous SRAM controller.
//   wb_clk_i / wb_rst_i       - clock, synchronous active-high reset
//   wb_dat_i / wb_dat_o       - per-port write data / registered read data
//   wb_adr_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i - per-port request
//   wb_ack_o                  - per-port one-cycle acknowledge
//   sram_addr_, sram_data_    - SRAM address and bidirectional data
//   sram_we_n_, sram_oe_n_, sram_ce_n_, sram_bw_n_ - registered strobes
// Each transfer is IDLE -> ACCESS (WAIT+1 cycles) -> ACK. The ACK cycle
// has all strobes high and the bus released, which doubles as turnaround.
module wb_mpsram
    import wb_mpsram_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DW     = 16,
    parameter int AW     = 18,
    parameter int RR     = 0,
    parameter int WAIT   = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NPORTS*DW-1:0]     wb_dat_i,
    output logic [NPORTS*DW-1:0]     wb_dat_o,
    input  logic [NPORTS*AW-1:0]     wb_adr_i,
    input  logic [NPORTS-1:0]        wb_we_i,
    input  logic [NPORTS*DW/8-1:0]   wb_sel_i,
    input  logic [NPORTS-1:0]        wb_stb_i,
    input  logic [NPORTS-1:0]        wb_cyc_i,
    output logic [NPORTS-1:0]        wb_ack_o,
    output logic [AW-1:0]            sram_addr_,
    inout  wire  [DW-1:0]            sram_data_,
    output logic                     sram_we_n_,
    output logic                     sram_oe_n_,
    output logic                     sram_ce_n_,
    output logic [DW/8-1:0]          sram_bw_n_
);

    localparam int SW = DW / 8;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NPORTS-1:0]  req;
    logic [NPORTS-1:0]  grant;
    logic [NPORTS-1:0]  grant_q;
    logic [DW-1:0]      wdat_q;
    logic               we_q;
    logic               drive_q;
    logic               abort_q;
    logic               start;
    logic               cyc_g;

    logic [AW-1:0]      sel_adr;
    logic [DW-1:0]      sel_dat;
    logic [SW-1:0]      sel_bw_n;
    logic               sel_we;

    assign req   = wb_stb_i & wb_cyc_i;
    assign start = (state_q == IDLE) && (|req);
    assign cyc_g = |(wb_cyc_i & grant_q);

    assign sram_data_ = drive_q ? wdat_q : {DW{1'bz}};

    wb_rr_arbiter #(
        .NPORTS (NPORTS),
        .RR     (RR)
    ) u_arb (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .req    (req),
        .update (start),
        .grant  (grant)
    );

    // Request fields of the port the arbiter is granting this cycle.
    always_comb begin
        sel_adr  = '0;
        sel_dat  = '0;
        sel_bw_n = '1;
        sel_we   = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (grant[p]) begin
                sel_adr  = wb_adr_i[slice_lo(p, AW) +: AW];
                sel_dat  = wb_dat_i[slice_lo(p, DW) +: DW];
                sel_bw_n = ~wb_sel_i[slice_lo(p, SW) +: SW];
                sel_we   = wb_we_i[p];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            drive_q    <= 1'b0;
            abort_q    <= 1'b0;
            sram_addr_ <= '0;
            sram_we_n_ <= 1'b1;
            sram_oe_n_ <= 1'b1;
            sram_ce_n_ <= 1'b1;
            sram_bw_n_ <= '1;
            wb_ack_o   <= '0;
            wb_dat_o   <= '0;
        end else begin
            wb_ack_o <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q    <= grant;
                        sram_addr_ <= sel_adr;
                        wdat_q     <= sel_dat;
                        we_q       <= sel_we;
                        sram_bw_n_ <= sel_bw_n;
                        sram_ce_n_ <= 1'b0;
                        sram_we_n_ <= ~sel_we;
                        sram_oe_n_ <= sel_we;
                        drive_q    <= sel_we;
                        abort_q    <= 1'b0;
                        cnt_q      <= CNT_W'(WAIT);
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Sticky: a cyc drop anywhere in ACCESS kills the ack,
                    // but the SRAM cycle itself runs to completion.
                    if (!cyc_g) begin
                        abort_q <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        for (int p = 0; p < NPORTS; p++) begin
                            if (grant_q[p]) begin
                                if (!we_q) begin
                                    wb_dat_o[slice_lo(p, DW) +: DW] <= sram_data_;
                                end
                                wb_ack_o[p] <= wb_cyc_i[p] & ~abort_q;
                            end
                        end
                        sram_ce_n_ <= 1'b1;
                        sram_we_n_ <= 1'b1;
                        sram_oe_n_ <= 1'b1;
                        sram_bw_n_ <= '1;
                        drive_q    <= 1'b0;
                        state_q    <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mpsram.sv
// tb_wb_mpsram: directed bench with two controller instances, each backed
// by a small behavioural SRAM.
//   u_two  : NPORTS=2, fixed priority, WAIT=1
//   u_four : NPORTS=4, round-robin,    WAIT=3
module tb_wb_mpsram;
    import wb_mpsram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- two-port instance ----------------
    logic        rst2;
    logic [1:0]  stb2, cyc2, we2;
    logic [35:0] adr2;
    logic [31:0] wd2;
    logic [3:0]  sel2;
    logic [31:0] rd2;
    logic [1:0]  ack2;
    logic [17:0] sa2;
    wire  [15:0] sd2;
    logic        wen2, oen2, cen2;
    logic [1:0]  bwn2;
    logic [15:0] mem2 [0:1023];

    wb_mpsram #(.NPORTS(2), .DW(16), .AW(18), .RR(0), .WAIT(1)) u_two (
        .wb_clk_i(clk), .wb_rst_i(rst2),
        .wb_dat_i(wd2), .wb_dat_o(rd2), .wb_adr_i(adr2), .wb_we_i(we2),
        .wb_sel_i(sel2), .wb_stb_i(stb2), .wb_cyc_i(cyc2), .wb_ack_o(ack2),
        .sram_addr_(sa2), .sram_data_(sd2), .sram_we_n_(wen2),
        .sram_oe_n_(oen2), .sram_ce_n_(cen2), .sram_bw_n_(bwn2)
    );

    assign sd2 = (!cen2 && !oen2 && wen2) ? mem2[sa2[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!cen2 && !wen2) begin
            if (!bwn2[0]) mem2[sa2[9:0]][7:0]  <= sd2[7:0];
            if (!bwn2[1]) mem2[sa2[9:0]][15:8] <= sd2[15:8];
        end
    end

    // ---------------- four-port instance ----------------
    logic        rst4;
    logic [3:0]  stb4, cyc4, we4;
    logic [71:0] adr4;
    logic [63:0] wd4;
    logic [7:0]  sel4;
    logic [63:0] rd4;
    logic [3:0]  ack4;
    logic [17:0] sa4;
    wire  [15:0] sd4;
    logic        wen4, oen4, cen4;
    logic [1:0]  bwn4;
    logic [15:0] mem4 [0:1023];

    wb_mpsram #(.NPORTS(4), .DW(16), .AW(18), .RR(1), .WAIT(3)) u_four (
        .wb_clk_i(clk), .wb_rst_i(rst4),
        .wb_dat_i(wd4), .wb_dat_o(rd4), .wb_adr_i(adr4), .wb_we_i(we4),
        .wb_sel_i(sel4), .wb_stb_i(stb4), .wb_cyc_i(cyc4), .wb_ack_o(ack4),
        .sram_addr_(sa4), .sram_data_(sd4), .sram_we_n_(wen4),
        .sram_oe_n_(oen4), .sram_ce_n_(cen4), .sram_bw_n_(bwn4)
    );

    assign sd4 = (!cen4 && !oen4 && wen4) ? mem4[sa4[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!cen4 && !wen4) begin
            if (!bwn4[0]) mem4[sa4[9:0]][7:0]  <= sd4[7:0];
            if (!bwn4[1]) mem4[sa4[9:0]][15:8] <= sd4[15:8];
        end
    end

    // ---------------- monitors ----------------
    int overlap = 0;
    int wel2    = 0;
    always @(negedge clk) begin
        if ($countones(ack2) > 1) overlap++;
        if ($countones(ack4) > 1) overlap++;
        if (!wen2) wel2++;
    end

    // One transfer on u_two. lat is the number of negedges from the launch
    // until ack (-1 if none within the bound); drop_at>0 removes cyc/stb at
    // that negedge. bw_mid is sram_bw_n_ in the first ACCESS cycle.
    task automatic xfer2(input int p, input logic w, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] s, input int drop_at,
                         output logic [15:0] rd, output int lat, output logic [1:0] bw_mid);
        @(negedge clk);
        stb2[p] = 1'b1; cyc2[p] = 1'b1; we2[p] = w;
        adr2[p*18 +: 18] = a; wd2[p*16 +: 16] = d; sel2[p*2 +: 2] = s;
        lat = -1;
        bw_mid = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bw_mid = bwn2;
            if (k == drop_at) begin
                stb2[p] = 1'b0; cyc2[p] = 1'b0;
            end
            if (ack2[p]) begin
                lat = k;
                break;
            end
        end
        stb2[p] = 1'b0; cyc2[p] = 1'b0;
        rd = rd2[p*16 +: 16];
    endtask

    logic [15:0] rd;
    logic [1:0]  bw;
    int          lat;
    int          wel0;
    logic [3:0]  seq2;
    int          n2, n0;
    logic [15:0] rd_p0, rd_p1;
    logic [19:0] seq4;
    int          n4;
    int          t4 [0:4];
    int          acks;

    initial begin
        rst2 = 1'b1; stb2 = '0; cyc2 = '0; we2 = '0; adr2 = '0; wd2 = '0; sel2 = '0;
        rst4 = 1'b1; stb4 = '0; cyc4 = '0; we4 = '0; adr4 = '0; wd4 = '0; sel4 = '0;
        repeat (3) @(negedge clk);

        check("rst_ce_n", 64'(cen2), 64'(1));
        check("rst_we_n", 64'(wen2), 64'(1));
        check("rst_oe_n", 64'(oen2), 64'(1));
        check("rst_bw_n", 64'(bwn2), 64'(2'b11));
        check("rst_addr", 64'(sa2), 64'(0));
        check("rst_ack",  64'(ack2), 64'(0));
        check("rst_dat_o", 64'(rd2), 64'(0));
        check("rst_drive", 64'(u_two.drive_q), 64'(0));
        rst2 = 1'b0; rst4 = 1'b0;

        // write 0xBEEF then read it back
        wel0 = wel2;
        xfer2(0, 1'b1, 18'h00010, 16'hBEEF, 2'b11, 0, rd, lat, bw);
        check("wr_lat", 64'(lat), 64'(3));
        check("wr_we_low_cycles", 64'(wel2 - wel0), 64'(2));
        check("wr_mem", 64'(mem2[16]), 64'(16'hBEEF));
        xfer2(0, 1'b0, 18'h00010, 16'h0000, 2'b11, 0, rd, lat, bw);
        check("rd_lat", 64'(lat), 64'(3));
        check("rd_data", 64'(rd), 64'(16'hBEEF));

        // upper-byte write over 0xFFFF
        xfer2(0, 1'b1, 18'h00020, 16'hFFFF, 2'b11, 0, rd, lat, bw);
        xfer2(0, 1'b1, 18'h00020, 16'h1234, 2'b10, 0, rd, lat, bw);
        check("byte_bw_n", 64'(bw), 64'(2'b01));
        xfer2(0, 1'b0, 18'h00020, 16'h0000, 2'b11, 0, rd, lat, bw);
        check("byte_rd", 64'(rd), 64'(16'h12FF));

        // abort: port 1 drops cyc in ACCESS; write still lands
        xfer2(1, 1'b1, 18'h00030, 16'h5555, 2'b11, 1, rd, lat, bw);
        check("abort_no_ack", 64'(lat), 64'(-1));
        xfer2(1, 1'b0, 18'h00030, 16'h0000, 2'b11, 0, rd, lat, bw);
        check("abort_rd_lat", 64'(lat), 64'(3));
        check("abort_rd", 64'(rd), 64'(16'h5555));

        // fixed priority: port 0 holds for 3 transfers, port 1 waits
        @(negedge clk);
        adr2 = {18'h00020, 18'h00010};
        we2 = 2'b00; sel2 = 4'hF; stb2 = 2'b11; cyc2 = 2'b11;
        seq2 = '0; n2 = 0; n0 = 0; rd_p0 = '0; rd_p1 = '0;
        for (int k = 0; k < 60 && n2 < 4; k++) begin
            @(negedge clk);
            if (ack2[0]) begin
                seq2 = {seq2[2:0], 1'b0}; n2++; n0++; rd_p0 = rd2[15:0];
                if (n0 == 3) begin stb2[0] = 1'b0; cyc2[0] = 1'b0; end
            end
            if (ack2[1]) begin
                seq2 = {seq2[2:0], 1'b1}; n2++; rd_p1 = rd2[31:16];
                stb2[1] = 1'b0; cyc2[1] = 1'b0;
            end
        end
        stb2 = '0; cyc2 = '0;
        check("prio_ack_count", 64'(n2), 64'(4));
        check("prio_order", 64'(seq2), 64'(4'b0001));
        check("prio_rd_p0", 64'(rd_p0), 64'(16'hBEEF));
        check("prio_rd_p1", 64'(rd_p1), 64'(16'h12FF));

        // round-robin: all four ports request continuously
        @(negedge clk);
        we4 = '0; sel4 = 8'hFF; stb4 = 4'hF; cyc4 = 4'hF;
        seq4 = '0; n4 = 0;
        for (int k = 1; k <= 100 && n4 < 5; k++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (ack4[p] && n4 < 5) begin
                    seq4 = {seq4[15:0], 4'(p)};
                    t4[n4] = k;
                    n4++;
                end
            end
        end
        stb4 = '0; cyc4 = '0;
        check("rr_ack_count", 64'(n4), 64'(5));
        check("rr_order", 64'(seq4), 64'(20'h01230));
        check("rr_first_lat", 64'(t4[0]), 64'(5));
        check("rr_period", 64'(t4[1] - t4[0]), 64'(6));

        // reset pulse during a WAIT=3 write on port 2
        repeat (2) @(negedge clk);
        we4[2] = 1'b1; adr4[36 +: 18] = 18'h00005; wd4[32 +: 16] = 16'hAAAA;
        sel4[4 +: 2] = 2'b11; stb4[2] = 1'b1; cyc4[2] = 1'b1;
        @(negedge clk);
        check("mid_ce_n", 64'(cen4), 64'(0));
        check("mid_bus", 64'(sd4), 64'(16'hAAAA));
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        check("rstmid_ce_n", 64'(cen4), 64'(1));
        check("rstmid_we_n", 64'(wen4), 64'(1));
        check("rstmid_oe_n", 64'(oen4), 64'(1));
        check("rstmid_drive", 64'(u_four.drive_q), 64'(0));
        check("rstmid_state", 64'(u_four.state_q), 64'(IDLE));
        check("rstmid_ack", 64'(ack4), 64'(0));
        rst4 = 1'b0; stb4 = '0; cyc4 = '0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack4 != '0) acks++;
        end
        check("rstmid_no_late_ack", 64'(acks), 64'(0));
        check("rstmid_dat_o", 64'(rd4[47:32]), 64'(0));

        check("ack_overlap", 64'(overlap), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_mpsram.md
# wb_mpsram

Parametrised multi-port Wishbone-to-asynchronous-SRAM controller. It is the successor to the two-port fixed-priority SRAM bridge and generalises port count, data and address width, arbitration mode and SRAM access wait states. It sits between the CPU, video and DMA Wishbone masters and the board SRAM pads. It is a sequential block: a registered grant, a wait-state counter, registered read data and a one-cycle ack per transfer.

## Interface
- NPORTS, 2: number of Wishbone slave ports (1..8); port 0 has the lowest index.
- DW, 16: data width (multiple of 8).
- AW, 18: SRAM word-address width.
- RR, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- WAIT, 1: extra SRAM access cycles (0..15).
- wb_clk_i  in  1  clock for the whole block.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_dat_i  in  NPORTS*DW  write data; port p occupies bits [p*DW +: DW].
- wb_dat_o  out  NPORTS*DW  registered read data, per port.
- wb_adr_i  in  NPORTS*AW  word address, per port.
- wb_we_i  in  NPORTS  write enable, per port.
- wb_sel_i  in  NPORTS*DW/8  byte selects, per port.
- wb_stb_i, wb_cyc_i  in  NPORTS each  strobe and cycle, per port.
- wb_ack_o  out  NPORTS  acknowledge, per port; at most one bit is high in any cycle.
- sram_addr_  out  AW  registered SRAM address.
- sram_data_  inout  DW  SRAM data bus.
- sram_we_n_, sram_oe_n_, sram_ce_n_  out  1 each  active-low strobes, registered.
- sram_bw_n_  out  DW/8  active-low byte enables, registered.

## Operation
- Request for port p: req[p] = wb_stb_i[p] & wb_cyc_i[p].
- FSM states: IDLE, ACCESS, ACK.
- IDLE, any req:
  - Arbitrate and latch the one-hot grant.
  - Register address, write data, ~sel and we from the granted port.
  - Load cnt = WAIT; go to ACCESS.
- IDLE, no req: stay in IDLE; all SRAM strobes high.
- ACCESS:
  - sram_ce_n_ low.
  - Write: sram_we_n_ low and sram_data_ driven with the latched data.
  - Read: sram_oe_n_ low; sram_data_ is Z.
  - If cnt ≠ 0, decrement. If cnt = 0:
    - on a read, capture sram_data_ into the granted port's wb_dat_o slice;
    - go to ACK.
- ACK:
  - All strobes high; sram_data_ released to Z.
  - wb_ack_o[grant] = wb_cyc_i[grant].
  - Go to IDLE. This also provides the bus-turnaround cycle.
- Fixed mode: the lowest index with req set wins.
- RR mode:
  - The search starts at last+1 and wraps modulo NPORTS.
  - `last` updates to the granted index on entry to ACCESS.
  - `last` resets to NPORTS-1, so port 0 wins first.
- Abort: if the granted port drops cyc during ACCESS, the SRAM cycle still completes (a write is committed) and the ack is suppressed.
- Changes to request inputs from non-granted ports during ACCESS or ACK have no effect.
- Reset values:
  - sram_we_n_, sram_oe_n_, sram_ce_n_ = 1; sram_bw_n_ = all 1; sram_addr_ = 0; sram_data_ = Z.
  - wb_ack_o = 0; wb_dat_o = 0; state = IDLE; cnt = 0.
- Reset in mid-transfer: at the next edge, return to IDLE, raise all strobes, release the bus, issue no ack, and discard the pending read.

## Timing
- Request sampled in IDLE at edge T; SRAM pins valid after T+1.
- ACCESS lasts WAIT+1 cycles; ack is high during cycle T+2+WAIT, with wb_dat_o already valid.
- Ack is exactly one cycle. A master holding stb after its ack is seen as a new request at the next IDLE.
- Peak throughput is one transfer per WAIT+3 cycles.
- Write setup: address and data are stable one cycle before the ACK cycle, and we_n rises together with oe_n/ce_n.

## Structure
- Package wb_mpsram_pkg holds:
  - the state enum (IDLE/ACCESS/ACK);
  - the WAIT counter width constant (4 bits);
  - a helper function for port slice offsets.
- Sub-module wb_rr_arbiter:
  - inputs: NPORTS req, mode RR, and an update strobe;
  - output: a one-hot grant;
  - it owns the `last` pointer.
- The FSM, the data path and the SRAM pad registers stay in wb_mpsram.

## Test plan
- NPORTS=2, RR=0, WAIT=1: port 0 writes 0xBEEF to 0x00010 with sel=2'b11, then reads it back → rdata 0xBEEF, each ack at T+3, we_n low for 2 cycles.
- Simultaneous requests, RR=0: ports 0 and 1 both request; port 0 holds stb for 3 transfers → port 0 gets 3 acks before port 1 gets any.
- NPORTS=4, RR=1: all ports request continuously → grant order 0,1,2,3,0 and no ack overlap.
- Byte write, DW=16: write 0x1234 with sel=2'b10 over a stored 0xFFFF → sram_bw_n_=2'b01 and readback 0x12FF.
- Abort: port 1 drops cyc in ACCESS during a write of 0x5555 → no ack, and a later read returns 0x5555.
- Reset pulse in mid-ACCESS (WAIT=3) → strobes high and Z at the next edge, no ack, state IDLE.
